// File: rtl/core_div_pkg.sv
// Shared RV32M divider definitions: operation encodings, register-file bus widths
// and the constant values written onto the register-file write port.
package core_div_pkg;

  localparam int RegistersAddressBus = 5;
  localparam int RegistersByteBus    = 32;

  localparam logic [1:0] DivOpDiv  = 2'b00;
  localparam logic [1:0] DivOpDivu = 2'b01;
  localparam logic [1:0] DivOpRem  = 2'b10;
  localparam logic [1:0] DivOpRemu = 2'b11;

  localparam logic [RegistersAddressBus-1:0] ZeroReg  = '0;
  localparam logic [RegistersByteBus-1:0]    ZeroWord = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

endpackage

// File: rtl/core_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one restoring-division step per cycle,
// result written back to the register file through a single-cycle write pulse.
module core_div
  import core_div_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_in,
  input  logic [1:0]                     op_in,
  input  logic [RegistersByteBus-1:0]    dividend_in,
  input  logic [RegistersByteBus-1:0]    divisor_in,
  input  logic [RegistersAddressBus-1:0] rd_in,
  input  logic                           kill_in,
  output logic                           stall_out,
  output logic                           busy_out,
  output logic                           we_out,
  output logic [RegistersAddressBus-1:0] write_addr_out,
  output logic [RegistersByteBus-1:0]    write_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int CntW = $clog2(DIV_CYCLES + 1);
  localparam logic [CntW-1:0] LastCount = CntW'(DIV_CYCLES);

  state_t state, state_next;

  logic [CntW-1:0]                count;
  logic                           is_rem;
  logic [RegistersAddressBus-1:0] rd;
  logic [RegistersByteBus-1:0]    rem;
  logic [RegistersByteBus-1:0]    quo;
  logic [RegistersByteBus-1:0]    divisor;
  logic                           neg_quo;
  logic                           neg_rem;
  logic [RegistersByteBus-1:0]    result;

  logic                           start_ok;
  logic                           is_signed;
  logic                           a_neg;
  logic                           b_neg;
  logic [RegistersByteBus-1:0]    a_abs;
  logic [RegistersByteBus-1:0]    b_abs;
  logic [RegistersByteBus:0]      shifted;
  logic                           borrow;
  logic [RegistersByteBus-1:0]    diff;

  assign start_ok = (state == IDLE) && start_in && !kill_in;

  // Operand conditioning and the restoring step; the 33-bit shifted remainder keeps
  // the bit that would fall off the top when the divisor is close to 2^32.
  always_comb begin
    is_signed = !op_in[0];
    a_neg     = is_signed && dividend_in[RegistersByteBus-1];
    b_neg     = is_signed && divisor_in[RegistersByteBus-1];
    a_abs     = a_neg ? -dividend_in : dividend_in;
    b_abs     = b_neg ? -divisor_in : divisor_in;
    shifted   = {rem, quo[RegistersByteBus-1]};
    borrow    = shifted < {1'b0, divisor};
    diff      = shifted[RegistersByteBus-1:0] - divisor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = CALC;
      CALC: begin
        if (kill_in) begin
          state_next = IDLE;
        end else if (count == LastCount) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A zero divisor preloads the architectural result and a full counter, so the
  // next edge finalizes straight into DONE without any iterations.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      is_rem  <= 1'b0;
      rd      <= ZeroReg;
      rem     <= ZeroWord;
      quo     <= ZeroWord;
      divisor <= ZeroWord;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      result  <= ZeroWord;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            is_rem <= op_in[1];
            rd     <= rd_in;
            if (divisor_in == ZeroWord) begin
              quo     <= '1;
              rem     <= dividend_in;
              divisor <= ZeroWord;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
              count   <= LastCount;
            end else begin
              quo     <= a_abs;
              rem     <= ZeroWord;
              divisor <= b_abs;
              neg_quo <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              count   <= '0;
            end
          end
        end
        CALC: begin
          if (count != LastCount) begin
            rem   <= borrow ? shifted[RegistersByteBus-1:0] : diff;
            quo   <= {quo[RegistersByteBus-2:0], !borrow};
            count <= count + CntW'(1);
          end else if (is_rem) begin
            result <= neg_rem ? -rem : rem;
          end else begin
            result <= neg_quo ? -quo : quo;
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

  // Stall drops in DONE so the next instruction issues alongside the write-back.
  always_comb begin
    stall_out      = !rst && (((state == IDLE) && start_ok) || (state == CALC));
    busy_out       = (state == CALC) || (state == DONE);
    we_out         = WriteDisable;
    write_addr_out = ZeroReg;
    write_data_out = ZeroWord;
    if (state == DONE) begin
      we_out         = (rd != ZeroReg) ? WriteEnable : WriteDisable;
      write_addr_out = rd;
      write_data_out = result;
    end
  end

endmodule

// File: tb/tb_core_div.sv
// Directed bench for core_div: a table of operations with hand-computed results and
// latencies, plus sequences for kill, ignored starts, rd=0 and mid-operation reset.
module tb_core_div;
  import core_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [1:0]  op_in;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic [4:0]  rd_in;
  logic        kill_in;
  logic        stall_out;
  logic        busy_out;
  logic        we_out;
  logic [4:0]  write_addr_out;
  logic [31:0] write_data_out;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  core_div #(.DIV_CYCLES(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .op_in          (op_in),
    .dividend_in    (dividend_in),
    .divisor_in     (divisor_in),
    .rd_in          (rd_in),
    .kill_in        (kill_in),
    .stall_out      (stall_out),
    .busy_out       (busy_out),
    .we_out         (we_out),
    .write_addr_out (write_addr_out),
    .write_data_out (write_data_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives a one-cycle start; returns #1 after the edge that samples it (edge 0).
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    @(negedge clk);
    op_in       = op;
    dividend_in = a;
    divisor_in  = b;
    rd_in       = rd;
    start_in    = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
  endtask

  // Samples each negedge; k counts edges since the start edge, beginning at base.
  task automatic watch(input int base, input int last, output int first_k, output logic [31:0] data,
                       output logic [4:0] addr, output int pulses, output logic stall0,
                       output logic busy0, output logic stall_p, output logic busy_p);
    first_k = -1;
    data    = '0;
    addr    = '0;
    pulses  = 0;
    stall0  = 1'b0;
    busy0   = 1'b0;
    stall_p = 1'b0;
    busy_p  = 1'b0;
    for (int k = base; k <= last; k++) begin
      @(negedge clk);
      if (k == base) begin
        stall0 = stall_out;
        busy0  = busy_out;
      end
      if (we_out) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          data    = write_data_out;
          addr    = write_addr_out;
          stall_p = stall_out;
          busy_p  = busy_out;
        end
      end
    end
  endtask

  initial begin
    int          fk;
    int          np;
    logic [31:0] d;
    logic [4:0]  ad;
    logic        s0, b0, sp, bp;
    int          early;

    vecs[0]  = '{"divu_100_7",    DivOpDivu, 32'd100,        32'd7,          5'd1,  32'd14,         33};
    vecs[1]  = '{"remu_100_7",    DivOpRemu, 32'd100,        32'd7,          5'd2,  32'd2,          33};
    vecs[2]  = '{"div_m7_2",      DivOpDiv,  32'hFFFFFFF9,   32'd2,          5'd3,  32'hFFFFFFFD,   33};
    vecs[3]  = '{"rem_m7_2",      DivOpRem,  32'hFFFFFFF9,   32'd2,          5'd4,  32'hFFFFFFFF,   33};
    vecs[4]  = '{"div_7_m2",      DivOpDiv,  32'd7,          32'hFFFFFFFE,   5'd5,  32'hFFFFFFFD,   33};
    vecs[5]  = '{"divu_5_0",      DivOpDivu, 32'd5,          32'd0,          5'd6,  32'hFFFFFFFF,   1};
    vecs[6]  = '{"rem_5_0",       DivOpRem,  32'd5,          32'd0,          5'd7,  32'd5,          1};
    vecs[7]  = '{"div_ovf",       DivOpDiv,  32'h80000000,   32'hFFFFFFFF,   5'd8,  32'h80000000,   33};
    vecs[8]  = '{"rem_ovf",       DivOpRem,  32'h80000000,   32'hFFFFFFFF,   5'd9,  32'd0,          33};
    vecs[9]  = '{"divu_max_1",    DivOpDivu, 32'hFFFFFFFF,   32'd1,          5'd10, 32'hFFFFFFFF,   33};
    vecs[10] = '{"remu_max_16",   DivOpRemu, 32'hFFFFFFFF,   32'd16,         5'd11, 32'd15,         33};
    vecs[11] = '{"div_m100_m7",   DivOpDiv,  32'hFFFFFF9C,   32'hFFFFFFF9,   5'd12, 32'd14,         33};
    vecs[12] = '{"rem_100_m7",    DivOpRem,  32'd100,        32'hFFFFFFF9,   5'd13, 32'd2,          33};
    vecs[13] = '{"remu_7_bigdiv", DivOpRemu, 32'd7,          32'hFFFFFFF0,   5'd31, 32'd7,          33};

    rst         = 1'b1;
    start_in    = 1'b0;
    kill_in     = 1'b0;
    op_in       = '0;
    dividend_in = '0;
    divisor_in  = '0;
    rd_in       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_we",    {31'd0, we_out},         32'd0);
    checkOutput("reset_busy",  {31'd0, busy_out},       32'd0);
    checkOutput("reset_stall", {31'd0, stall_out},      32'd0);
    checkOutput("reset_addr",  {27'd0, write_addr_out}, 32'd0);
    checkOutput("reset_data",  write_data_out,          32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      watch(0, 40, fk, d, ad, np, s0, b0, sp, bp);
      checkOutput({vecs[i].name, "_lat"},    fk,              vecs[i].lat);
      checkOutput({vecs[i].name, "_data"},   d,               vecs[i].exp);
      checkOutput({vecs[i].name, "_addr"},   {27'd0, ad},     {27'd0, vecs[i].rd});
      checkOutput({vecs[i].name, "_pulses"}, np,              32'd1);
      checkOutput({vecs[i].name, "_stall0"}, {31'd0, s0},     32'd1);
      checkOutput({vecs[i].name, "_busy0"},  {31'd0, b0},     32'd1);
      checkOutput({vecs[i].name, "_stallD"}, {31'd0, sp},     32'd0);
      checkOutput({vecs[i].name, "_busyD"},  {31'd0, bp},     32'd1);
    end

    // Kill sampled at edge 10, then a fresh start sampled at edge 12.
    applyStimulus(DivOpDivu, 32'd1000, 32'd9, 5'd14);
    early = 0;
    repeat (10) begin
      @(negedge clk);
      if (we_out) early++;
    end
    kill_in = 1'b1;
    @(posedge clk);
    #1;
    kill_in = 1'b0;
    @(negedge clk);
    if (we_out) early++;
    checkOutput("kill_idle_busy", {31'd0, busy_out}, 32'd0);
    applyStimulus(DivOpRemu, 32'd1000, 32'd9, 5'd15);
    watch(0, 40, fk, d, ad, np, s0, b0, sp, bp);
    checkOutput("kill_no_we",     early,       32'd0);
    checkOutput("restart_lat",    fk,          32'd33);
    checkOutput("restart_data",   d,           32'd1);
    checkOutput("restart_pulses", np,          32'd1);
    checkOutput("restart_addr",   {27'd0, ad}, 32'd15);

    // Start pulses during CALC must not disturb or queue behind the running op.
    applyStimulus(DivOpDivu, 32'd100, 32'd7, 5'd3);
    repeat (5) @(negedge clk);
    op_in       = DivOpRemu;
    dividend_in = 32'd50;
    divisor_in  = 32'd3;
    rd_in       = 5'd9;
    start_in    = 1'b1;
    repeat (3) @(negedge clk);
    start_in = 1'b0;
    watch(8, 45, fk, d, ad, np, s0, b0, sp, bp);
    checkOutput("ignore_lat",    fk,          32'd33);
    checkOutput("ignore_data",   d,           32'd14);
    checkOutput("ignore_addr",   {27'd0, ad}, 32'd3);
    checkOutput("ignore_pulses", np,          32'd1);

    applyStimulus(DivOpDivu, 32'd100, 32'd7, 5'd0);
    watch(0, 40, fk, d, ad, np, s0, b0, sp, bp);
    checkOutput("rd0_pulses", np, 32'd0);

    // Reset sampled at edge 5 of CALC.
    applyStimulus(DivOpDiv, 32'd12345, 32'd11, 5'd20);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_we",    {31'd0, we_out},         32'd0);
    checkOutput("rst_mid_busy",  {31'd0, busy_out},       32'd0);
    checkOutput("rst_mid_stall", {31'd0, stall_out},      32'd0);
    checkOutput("rst_mid_addr",  {27'd0, write_addr_out}, 32'd0);
    checkOutput("rst_mid_data",  write_data_out,          32'd0);
    rst = 1'b0;
    watch(6, 45, fk, d, ad, np, s0, b0, sp, bp);
    checkOutput("rst_mid_pulses", np, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
